// File: rtl/layers_drain_pkg.sv
// rtl/layers_drain_pkg.sv - shared constants and types for the layers result drain
package layers_drain_pkg;

    // Config address map; each block owns one unique address
    localparam int unsigned CFG_LAYERS = 0;
    localparam int unsigned CFG_DRAIN  = 1;

    // One-hot drain states
    typedef enum logic [2:0] {
        ST_RESET = 3'b001,
        ST_IDLE  = 3'b010,
        ST_SEND  = 3'b100
    } drain_state_t;

    // Counter width for n items, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layers_drain.sv
// rtl/layers_drain.sv - serialises wide result vectors into framed narrow beats
module layers_drain
    import layers_drain_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int DEPTH_NB   = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int STR_WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] result,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [STR_WIDTH-1:0]          str_data,
    output logic                          str_val,
    output logic                          str_last,
    input  logic                          str_rdy
);

    localparam int VEC_W   = DEPTH_NB * IMG_WIDTH;
    localparam int BEAT_NB = VEC_W / STR_WIDTH;
    localparam int BEAT_CW = cnt_width(BEAT_NB);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEAT_NB - 1);

    drain_state_t         state;
    drain_state_t         state_nxt;
    logic [VEC_W-1:0]     data_buf;
    logic [BEAT_CW-1:0]   beat_cnt;
    logic [15:0]          res_cnt;
    logic [15:0]          frame_nb;

    logic cfg_hit;
    logic at_last_beat;
    logic beat_xfer;
    logic load;

    // Only the low 16 config bits carry the frame length
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data[CFG_DWIDTH-1:16];

    assign cfg_hit      = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_DRAIN));
    assign at_last_beat = (state == ST_SEND) && (beat_cnt == LAST_BEAT);
    assign beat_xfer    = (state == ST_SEND) && str_rdy;
    assign load         = (state == ST_IDLE) && result_val;

    // Outputs depend only on registered state, never on str_rdy or result_val
    assign str_data = data_buf[STR_WIDTH-1:0];
    assign str_last = at_last_beat && (frame_nb != 16'd0) && (res_cnt == frame_nb - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt  = state;
        result_rdy = 1'b0;
        str_val    = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                result_rdy = 1'b1;
                if (result_val) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                str_val = 1'b1;
                if (str_rdy && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // Shift buffer: loaded in IDLE, advanced one beat per accepted transfer
    always_ff @(posedge clk) begin
        if (load) begin
            data_buf <= result;
        end else if (beat_xfer) begin
            data_buf <= data_buf >> STR_WIDTH;
        end
    end

    // Beat counter within the current result
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (load) begin
            beat_cnt <= '0;
        end else if (beat_xfer) begin
            beat_cnt <= beat_cnt + BEAT_CW'(1);
        end
    end

    // Frame length and result counter; a config write overrides the end-of-result update
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_nb <= 16'd1;
            res_cnt  <= 16'd0;
        end else if (cfg_hit) begin
            frame_nb <= cfg_data[15:0];
            res_cnt  <= 16'd0;
        end else if (beat_xfer && at_last_beat) begin
            res_cnt <= str_last ? 16'd0 : res_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_layers_drain.sv
// tb/tb_layers_drain.sv - scoreboard bench for layers_drain
module tb_layers_drain;
    import layers_drain_pkg::*;

    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int DEPTH_NB   = 16;
    localparam int IMG_WIDTH  = 16;
    localparam int STR_WIDTH  = 64;
    localparam int VEC_W      = DEPTH_NB * IMG_WIDTH;
    localparam int BEAT_NB    = VEC_W / STR_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CFG_DWIDTH-1:0] cfg_data = '0;
    logic [CFG_AWIDTH-1:0] cfg_addr = '0;
    logic                  cfg_valid = 1'b0;
    logic [VEC_W-1:0]      result = '0;
    logic                  result_val = 1'b0;
    logic                  result_rdy;
    logic [STR_WIDTH-1:0]  str_data;
    logic                  str_val;
    logic                  str_last;
    logic                  str_rdy = 1'b1;

    typedef struct packed {
        logic [STR_WIDTH-1:0] data;
        logic                 last;
    } beat_t;

    beat_t                sb[$];
    int                   errors = 0;
    int                   checks = 0;
    int                   last_seen = 0;
    logic [15:0]          m_frame = 16'd1;
    logic [15:0]          m_cnt = 16'd0;
    logic                 prev_stall = 1'b0;
    logic [STR_WIDTH-1:0] prev_data = '0;
    logic                 bp_done = 1'b0;

    layers_drain #(
        .CFG_DWIDTH(CFG_DWIDTH),
        .CFG_AWIDTH(CFG_AWIDTH),
        .DEPTH_NB  (DEPTH_NB),
        .IMG_WIDTH (IMG_WIDTH),
        .STR_WIDTH (STR_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_valid (cfg_valid),
        .result    (result),
        .result_val(result_val),
        .result_rdy(result_rdy),
        .str_data  (str_data),
        .str_val   (str_val),
        .str_last  (str_last),
        .str_rdy   (str_rdy)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard on each accepted beat, checks stall stability
    always @(negedge clk) begin
        beat_t exp_beat;
        if (!rst && str_val) begin
            if (prev_stall) begin
                checks++;
                if (str_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected %h", str_data, prev_data);
                end
            end
            if (str_rdy) begin
                if (str_last) last_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %h last %b expected no beat", str_data, str_last);
                end else begin
                    exp_beat = sb.pop_front();
                    if (str_data !== exp_beat.data || str_last !== exp_beat.last) begin
                        errors++;
                        $display("FAIL beat: got data %h last %b expected data %h last %b",
                                 str_data, str_last, exp_beat.data, exp_beat.last);
                    end
                end
            end
            prev_stall = !str_rdy;
            prev_data  = str_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [VEC_W-1:0] mkvec(input logic [15:0] base);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < DEPTH_NB; i++) v[i*IMG_WIDTH +: IMG_WIDTH] = base + 16'(i);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rndvec();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < VEC_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference frame model: expected beats and last flag for one accepted result
    task automatic push_result(input logic [VEC_W-1:0] vec);
        beat_t b;
        logic  is_last;
        is_last = (m_frame != 16'd0) && (m_cnt == m_frame - 16'd1);
        for (int i = 0; i < BEAT_NB; i++) begin
            b.data = vec[i*STR_WIDTH +: STR_WIDTH];
            b.last = is_last && (i == BEAT_NB - 1);
            sb.push_back(b);
        end
        m_cnt = is_last ? 16'd0 : m_cnt + 16'd1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_frame = 16'd1;
        m_cnt   = 16'd0;
    endtask

    task automatic cfg_write(input logic [CFG_AWIDTH-1:0] addr, input logic [CFG_DWIDTH-1:0] data);
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_valid = 1'b1;
        if (addr == CFG_AWIDTH'(CFG_DRAIN)) begin
            m_frame = data[15:0];
            m_cnt   = 16'd0;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Offers one result; returns one step after the handshake edge
    task automatic send_result(input logic [VEC_W-1:0] vec);
        int t = 0;
        result     = vec;
        result_val = 1'b1;
        forever begin
            @(negedge clk);
            if (result_rdy) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got result_rdy %b expected 1", result_rdy);
                result_val = 1'b0;
                return;
            end
        end
        push_result(vec);
        @(posedge clk); #1;
        result_val = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (result_rdy !== 1'b0 || str_val !== 1'b0 || str_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy %b val %b last %b expected 0 0 0", result_rdy, str_val, str_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (result_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: got result_rdy %b expected 0", result_rdy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (result_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy_rise: got result_rdy %b expected 1", result_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int l0 = last_seen;
        send_result(mkvec(16'd0));
        @(negedge clk);
        checks++;
        if (str_val !== 1'b1 || str_data !== 64'h0003_0002_0001_0000 || str_last !== 1'b0) begin
            errors++;
            $display("FAIL single_first_beat: got val %b data %h last %b expected 1 0003000200010000 0",
                     str_val, str_data, str_last);
        end
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (result_rdy !== 1'b1 || str_val !== 1'b0) begin
            errors++;
            $display("FAIL single_back_idle: got rdy %b val %b expected 1 0", result_rdy, str_val);
        end
        @(posedge clk); #1;
        drain();
        checks++;
        if (last_seen - l0 != 1) begin
            errors++;
            $display("FAIL single_last_count: got %0d expected 1", last_seen - l0);
        end
    endtask

    task automatic test_backpressure();
        int l0;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd2);
        l0 = last_seen;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_result(rndvec());
                drain();
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk); #1;
                    str_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        str_rdy = 1'b1;
        checks++;
        if (last_seen - l0 != 3) begin
            errors++;
            $display("FAIL bp_last_count: got %0d expected 3", last_seen - l0);
        end
    endtask

    task automatic test_frame_count();
        int l0;
        cfg_write(CFG_AWIDTH'(CFG_LAYERS), 32'd5);
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd3);
        l0 = last_seen;
        for (int i = 0; i < 7; i++) send_result(mkvec(16'(16'h0100 * i)));
        drain();
        checks++;
        if (last_seen - l0 != 2) begin
            errors++;
            $display("FAIL frame_last_count: got %0d expected 2", last_seen - l0);
        end
    endtask

    task automatic test_hold_off();
        int n = 0;
        int t = 0;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd2);
        result_val = 1'b1;
        while (n < 3 && t < 300) begin
            result = rndvec();
            @(negedge clk);
            if (result_rdy) begin
                push_result(result);
                n++;
            end
            @(posedge clk); #1;
            t++;
        end
        result_val = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL holdoff_handshakes: got %0d expected 3", n);
        end
        drain();
    endtask

    task automatic test_frame_zero();
        int l0;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd0);
        l0 = last_seen;
        for (int i = 0; i < 5; i++) send_result(rndvec());
        drain();
        checks++;
        if (last_seen - l0 != 0) begin
            errors++;
            $display("FAIL zero_last_count: got %0d expected 0", last_seen - l0);
        end
    endtask

    task automatic test_cfg_last_beat();
        int l0;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd3);
        l0 = last_seen;
        send_result(rndvec());
        repeat (3) @(posedge clk);
        #1;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd2);
        drain();
        for (int i = 0; i < 2; i++) send_result(rndvec());
        drain();
        checks++;
        if (last_seen - l0 != 1) begin
            errors++;
            $display("FAIL cfg_restart_count: got %0d expected 1", last_seen - l0);
        end
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd1);
        l0 = last_seen;
        send_result(rndvec());
        repeat (3) @(posedge clk);
        #1;
        cfg_write(CFG_AWIDTH'(CFG_DRAIN), 32'd3);
        drain();
        for (int i = 0; i < 3; i++) send_result(rndvec());
        drain();
        checks++;
        if (last_seen - l0 != 2) begin
            errors++;
            $display("FAIL cfg_old_frame_count: got %0d expected 2", last_seen - l0);
        end
    endtask

    task automatic test_reset_mid_send();
        send_result(mkvec(16'h0500));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (str_val !== 1'b0 || str_last !== 1'b0) begin
            errors++;
            $display("FAIL midsend_reset: got val %b last %b expected 0 0", str_val, str_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        send_result(mkvec(16'h0600));
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_frame_count();
        test_hold_off();
        test_frame_zero();
        test_cfg_last_beat();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layers_drain.md
# layers_drain

Output-side partner of the `layers` block. It accepts one wide `result` vector (DEPTH_NB pixels of IMG_WIDTH bits) through the `result_val`/`result_rdy` handshake and serialises it into a narrower valid/ready stream of STR_WIDTH-bit beats for the write-back path. It counts results per frame and marks the final beat of each frame with `str_last`.

## Interface
- `CFG_DWIDTH`, 32, config data width
- `CFG_AWIDTH`, 5, config address width
- `DEPTH_NB`, 16, pixels per result vector
- `IMG_WIDTH`, 16, bits per pixel
- `STR_WIDTH`, 64, output beat width; must be a multiple of IMG_WIDTH, and DEPTH_NB*IMG_WIDTH must be a multiple of STR_WIDTH
- Derived: `BEAT_NB = DEPTH_NB*IMG_WIDTH/STR_WIDTH` (4 at defaults)
- `clk`  in  1  clock; the only clock
- `rst`  in  1  reset; synchronous, active-high
- `cfg_data`  in  CFG_DWIDTH  config word
- `cfg_addr`  in  CFG_AWIDTH  config address
- `cfg_valid`  in  1  config write strobe
- `result`  in  IMG_WIDTH*DEPTH_NB  result vector from `layers`
- `result_val`  in  1  result vector valid
- `result_rdy`  out  1  drain can accept a result vector
- `str_data`  out  STR_WIDTH  output beat
- `str_val`  out  1  beat valid
- `str_last`  out  1  final beat of the frame
- `str_rdy`  in  1  downstream accepts beat

## Operation
- Config: on `cfg_valid & (cfg_addr == CFG_DRAIN)`, `frame_nb <= cfg_data[15:0]` and `res_cnt <= 0`. `frame_nb` powers up as 16'd1. `frame_nb == 0` means `str_last` is never asserted.
- One-hot FSM with states RESET, IDLE, SEND:
  - RESET -> IDLE unconditionally. `rst` forces RESET.
  - IDLE: `result_rdy = 1`. When `result_val` is high, load `buf <= result` and `beat_cnt <= 0`, then go to SEND.
  - SEND: `str_val = 1` and `str_data = buf[STR_WIDTH-1:0]`. On `str_val & str_rdy`:
    - Shift `buf` right by STR_WIDTH and increment `beat_cnt`.
    - If `beat_cnt == BEAT_NB-1`, go to IDLE and update `res_cnt`.
- Ordering: pixel 0 (`result[IMG_WIDTH-1:0]`) goes out first, in the low lanes of beat 0.
- `str_last = SEND & (beat_cnt == BEAT_NB-1) & (frame_nb != 0) & (res_cnt == frame_nb-1)`.
- `res_cnt`:
  - Increments after each completed result.
  - Wraps to 0 on the same cycle as the beat where `str_last & str_rdy`.
  - The width-16 counter wraps naturally if `frame_nb == 0`.
- `result_rdy`, `str_val`, `str_last` and `str_data` are decoded from state and registers only. No input combinationally reaches an output.
- `str_data` stays stable while `str_val & !str_rdy`.

## Timing
- Reset values: `result_rdy = 0` (in RESET), `str_val = 0`, `str_last = 0`, `beat_cnt = 0`, `res_cnt = 0`. `str_data` is don't-care while `str_val = 0`.
- The first cycle after reset deasserts is RESET; `result_rdy` rises on the cycle after that.
- Latency: a handshake in cycle N puts the first beat on `str_val` in cycle N+1.
- With `str_rdy` held high, a result takes `BEAT_NB` cycles in SEND plus 1 in IDLE. Throughput is one result per `BEAT_NB+1` cycles.
- `result_rdy` is low throughout SEND. `result_val` seen in SEND is held off until IDLE.
- Config write while in SEND, same cycle as the last beat: the config write wins, so `res_cnt = 0`. `str_last` for that beat is evaluated against the old `frame_nb`/`res_cnt`.
- Reset mid-SEND discards the buffered vector. No partial frame is flagged.

## Structure
- `CFG_DRAIN` address constant goes in the shared `cfg_parameters.vh`, alongside `CFG_LAYERS`. It must be unique in that file.
- Single module, no sub-modules.
- The shift buffer is DEPTH_NB*IMG_WIDTH bits. `beat_cnt` is `clog2(BEAT_NB)` bits, minimum 1.

## Test plan
- **Reset:** hold `rst` 3 cycles -> `result_rdy`, `str_val`, `str_last` are 0; `result_rdy` = 1 two cycles after `rst` falls.
- **Single result:** `frame_nb = 1`, `str_rdy` = 1, `result` = pixel i holds value i (0..15) -> 4 beats: 0x0003_0002_0001_0000, 0x0007_0006_0005_0004, …; `str_last` only on beat 3; `result_rdy` back to 1 the next cycle.
- **Backpressure:** toggle `str_rdy` 1/0 pseudo-randomly -> `str_data` stable while stalled; beats in order; no beat lost or duplicated.
- **Frame counting:** `frame_nb = 3`, send 7 results -> `str_last` on the last beat of results 3 and 6 only; `res_cnt` = 1 at the end.
- **Hold-off:** `result_val` held high during SEND with a changing `result` -> only values present during IDLE handshakes are emitted.
- **Corner cases:**
  - `frame_nb = 0` -> `str_last` never asserted.
  - Config write during the last beat -> next `str_last` comes after `frame_nb` further results.
  - Reset mid-SEND -> `str_val` drops on the next cycle.
